// File: rtl/calc_seq.sv
// rtl/calc_seq.sv - bit-serial byte sequencer driving a shared 1-bit gate unit
module calc_seq (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [2:0] op,
   input  logic [7:0] a,
   input  logic [7:0] b,
   output logic       gate_a,
   output logic       gate_b,
   input  logic [7:0] gate_out,
   output logic       busy,
   output logic       done,
   output logic       err,
   output logic [7:0] result
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [2:0] OP_RESERVED = 3'd7;
   localparam logic [2:0] CNT_LAST    = 3'd7;

   state_t     state;
   state_t     state_nxt;
   logic [7:0] a_r;
   logic [7:0] b_r;
   logic [2:0] op_r;
   logic [2:0] cnt;
   logic       accept;
   logic       reserved;

   // start only counts in IDLE; op 7 short-circuits straight to DONE with err
   assign accept   = (state == IDLE) && start;
   assign reserved = (op == OP_RESERVED);

   // state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // next-state decode and state-derived outputs; gate pins are low outside RUN
   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      gate_a    = 1'b0;
      gate_b    = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_nxt = reserved ? DONE : RUN;
            end
         end
         RUN: begin
            busy   = 1'b1;
            gate_a = a_r[cnt];
            gate_b = b_r[cnt];
            if (cnt == CNT_LAST) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // operand latch, bit counter and progressive result capture (LSB first)
   always_ff @(posedge clk) begin
      if (rst) begin
         a_r    <= 8'h00;
         b_r    <= 8'h00;
         op_r   <= 3'd0;
         cnt    <= 3'd0;
         result <= 8'h00;
         err    <= 1'b0;
      end else begin
         if (accept) begin
            result <= 8'h00;
            if (reserved) begin
               err <= 1'b1;
            end else begin
               a_r  <= a;
               b_r  <= b;
               op_r <= op;
               cnt  <= 3'd0;
               err  <= 1'b0;
            end
         end else if (state == RUN) begin
            // gate unit is combinational, so its output for bit cnt is ready this cycle
            result[cnt] <= gate_out[op_r];
            cnt         <= cnt + 3'd1;
         end
      end
   end

endmodule
